// File: rtl/smc_pkg.sv
// Shared types and default dimensions for the SMC PWM generation stage.
package smc_pkg;

  localparam int SMC_N_CH  = 12;
  localparam int SMC_PER_W = 11;

  typedef enum logic [1:0] {
    ALIGN_OFF    = 2'b00,
    ALIGN_LEFT   = 2'b01,
    ALIGN_RIGHT  = 2'b10,
    ALIGN_CENTER = 2'b11
  } smc_align_e;

  typedef struct packed {
    logic                 sign;
    logic [SMC_PER_W-1:0] mag;
  } smc_duty_t;

endpackage

// File: rtl/smc_pwm_chan.sv
// One PWM channel: mode/duty shadow, duty saturation, compare against the
// shared counter, sign steering onto the pin pair and the output register.
module smc_pwm_chan
  import smc_pkg::*;
#(
  parameter int PER_W = SMC_PER_W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             phase_i,
  input  logic [PER_W-1:0] cnt_i,
  input  logic [PER_W-1:0] per_i,
  input  logic [1:0]       am_i,
  input  logic [PER_W:0]   dc_i,
  output logic             mnm_o,
  output logic             mnp_o
);

  logic [1:0]       am_q, am_d;
  logic [PER_W:0]   dc_q, dc_d;
  logic             mnm_q, mnm_d;
  logic             mnp_q, mnp_d;
  logic [PER_W-1:0] mag;
  logic [PER_W-1:0] thr;
  logic             pwm;

  always_comb begin
    am_d = load_i ? am_i : am_q;
    dc_d = load_i ? dc_i : dc_q;

    // Saturating to the period keeps per_i - mag from underflowing.
    mag = (dc_q[PER_W-1:0] > per_i) ? per_i : dc_q[PER_W-1:0];
    thr = per_i - mag;

    pwm = 1'b0;
    case (smc_align_e'(am_q))
      ALIGN_LEFT:   pwm = (cnt_i < mag);
      ALIGN_RIGHT:  pwm = (cnt_i >= thr);
      ALIGN_CENTER: pwm = phase_i ? (cnt_i < mag) : (cnt_i >= thr);
      default:      pwm = 1'b0;
    endcase

    mnp_d = run_i & pwm & ~dc_q[PER_W];
    mnm_d = run_i & pwm &  dc_q[PER_W];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      am_q  <= '0;
      dc_q  <= '0;
      mnm_q <= 1'b0;
      mnp_q <= 1'b0;
    end else begin
      am_q  <= am_d;
      dc_q  <= dc_d;
      mnm_q <= mnm_d;
      mnp_q <= mnp_d;
    end
  end

  assign mnm_o = mnm_q;
  assign mnp_o = mnp_q;

endmodule

// File: rtl/smc_pwm_gen.sv
// SMC PWM generator top: shared period counter, phase, period shadow and reload.
// Define SMC_DUTY_BUFFER_EN to double-buffer duty/mode as well as the period.
module smc_pwm_gen
  import smc_pkg::*;
#(
  parameter int N_CH  = SMC_N_CH,
  parameter int PER_W = SMC_PER_W
) (
  input  logic                      QCLK,
  input  logic                      QRESET,
  input  logic                      mcen_i,
  input  logic [PER_W-1:0]          mcper_i,
  input  logic [2*N_CH-1:0]         mcam_i,
  input  logic [(PER_W+1)*N_CH-1:0] mcdc_i,
  output logic [N_CH-1:0]           MNM,
  output logic [N_CH-1:0]           MNP,
  output logic                      period_end_o,
  output logic [PER_W-1:0]          cnt_o
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             phase_q, phase_d;
  logic             run;
  logic             last;
  logic             reload;
  logic             per_load;
  logic             duty_load;

  always_comb begin
    run    = mcen_i && (per_q != '0);
    last   = (cnt_q == per_q - PER_W'(1));
    reload = run && last && phase_q;

    // While the counter is stopped the shadows are transparent, so a
    // zero period can always be replaced without waiting for a reload.
    per_load = !run || reload;
`ifdef SMC_DUTY_BUFFER_EN
    duty_load = per_load;
`else
    duty_load = 1'b1;
`endif

    cnt_d   = '0;
    phase_d = 1'b0;
    if (run) begin
      if (last) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + PER_W'(1);
        phase_d = phase_q;
      end
    end

    per_d = per_load ? mcper_i : per_q;
  end

  always_ff @(posedge QCLK) begin
    if (QRESET) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      per_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      per_q   <= per_d;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      smc_pwm_chan #(
        .PER_W(PER_W)
      ) u_chan (
        .clk     (QCLK),
        .srst    (QRESET),
        .load_i  (duty_load),
        .run_i   (run),
        .phase_i (phase_q),
        .cnt_i   (cnt_q),
        .per_i   (per_q),
        .am_i    (mcam_i[2*gi +: 2]),
        .dc_i    (mcdc_i[(PER_W+1)*gi +: PER_W+1]),
        .mnm_o   (MNM[gi]),
        .mnp_o   (MNP[gi])
      );
    end
  endgenerate

  assign period_end_o = reload;
  assign cnt_o        = cnt_q;

endmodule
